act_lut_loader: RTL

Writable activation lookup table for the inference datapath. It holds `2**ADDR_WIDTH` entries of `DATA_WIDTH` bits (for example, the 12-bit-addressed sigmoid table) and loads them at run time from a valid/ready byte stream. A load FSM writes the stream into consecutive addresses starting at 0 and checks the stream length against `s_last`. The read port is synchronous with one cycle of latency and only returns table data once a complete, error-free load has finished.

---
 rtl/act_lut_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/act_lut_loader.sv
// act_lut_loader: writable activation lookup table.
// A valid/ready byte stream fills addresses 0..2**ADDR_WIDTH-1 in order; the
// stream length is checked against s_last. Reads are synchronous, with one
// cycle of latency. Reads return zero unless a complete, error-free load has
// finished.
module act_lut_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  busy,
    output logic                  loaded,
    output logic                  len_err,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic                    beat_s;

    // Output flags for a given state, packed as {s_ready, busy, loaded, len_err}.
    // The flags are loaded into registers together with the state, so each
    // output always agrees with the registered state.
    function automatic logic [3:0] state_flags(input state_t st);
        logic [3:0] flags;
        case (st)
            ST_LOAD:  flags = 4'b1100;
            ST_READY: flags = 4'b0010;
            ST_ERROR: flags = 4'b0001;
            ST_IDLE:  flags = 4'b0000;
            default:  flags = 4'b0000;
        endcase
        return flags;
    endfunction

    // A beat is a handshake on the stream port. s_ready is high only in LOAD.
    always_comb begin
        beat_s = s_valid && s_ready;
    end

    // Load FSM: tracks the write address, checks the stream length and drives
    // the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_addr_r <= ADDR_ZERO;
            {s_ready, busy, loaded, len_err} <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_READY, ST_ERROR: begin
                    if (load_start) begin
                        state_r   <= ST_LOAD;
                        wr_addr_r <= ADDR_ZERO;
                        {s_ready, busy, loaded, len_err} <= state_flags(ST_LOAD);
                    end else begin
                        state_r   <= state_r;
                        wr_addr_r <= wr_addr_r;
                        {s_ready, busy, loaded, len_err} <= state_flags(state_r);
                    end
                end
                ST_LOAD: begin
                    // load_start is ignored while a load is in progress.
                    if (beat_s) begin
                        wr_addr_r <= wr_addr_r + ADDR_ONE;
                        if (s_last && (wr_addr_r == ADDR_MAX)) begin
                            state_r <= ST_READY;
                            {s_ready, busy, loaded, len_err} <= state_flags(ST_READY);
                        end else if (s_last || (wr_addr_r == ADDR_MAX)) begin
                            // There are two error cases. s_last before the end
                            // of the table is a short load. A full table
                            // without s_last is a long load.
                            state_r <= ST_ERROR;
                            {s_ready, busy, loaded, len_err} <= state_flags(ST_ERROR);
                        end else begin
                            state_r <= ST_LOAD;
                            {s_ready, busy, loaded, len_err} <= state_flags(ST_LOAD);
                        end
                    end else begin
                        state_r   <= ST_LOAD;
                        wr_addr_r <= wr_addr_r;
                        {s_ready, busy, loaded, len_err} <= state_flags(ST_LOAD);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    wr_addr_r <= ADDR_ZERO;
                    {s_ready, busy, loaded, len_err} <= 4'b0000;
                end
            endcase
        end
    end

    // Table write port. Reset does not clear the contents, but a beat that
    // coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && beat_s) begin
            mem_r[wr_addr_r] <= s_data;
        end
    end

    // Registered read port. Data is masked to zero unless the table is
    // complete, so a partial or failed load is never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (loaded) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end
    end

endmodule
